doy_to_month_day: RTL and testbench



---
 rtl/date_pkg.sv | 17 +
 rtl/month_len_rom.sv | 21 ++
 rtl/doy_to_month_day.sv | 170 +++++++++++++++++
 tb/tb_doy_to_month_day.sv | 153 +++++++++++++++
 4 files changed

// File: rtl/date_pkg.sv
// Shared types and constants for the day-of-year to month/day display path.
package date_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SUB  = 2'd1,
    ST_BCD  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  // Digit code that the SevenSeg decoders render as an unlit digit.
  localparam logic [7:0] BLANK_CODE  = 8'd88;
  localparam int         MONTHS      = 12;
  localparam int         DAYS_NORMAL = 365;
  localparam int         DAYS_LEAP   = 366;

endpackage

// File: rtl/month_len_rom.sv
// Month-length lookup: number of days in a month, 0 for months outside 1..12.
module month_len_rom
  import date_pkg::*;
(
  input  logic [3:0] month_i,
  input  logic       leap_i,
  output logic [4:0] days_o
);

  always_comb begin
    days_o = 5'd0;
    if (month_i >= 4'd1 && month_i <= 4'(MONTHS)) begin
      case (month_i)
        4'd2:                      days_o = leap_i ? 5'd29 : 5'd28;
        4'd4, 4'd6, 4'd9, 4'd11:   days_o = 5'd30;
        default:                   days_o = 5'd31;
      endcase
    end
  end

endmodule

// File: rtl/doy_to_month_day.sv
// Sequential day-of-year to month/day converter producing tens/ones digit
// codes for the HEX display; walks one month per cycle, then one tens step per cycle.
module doy_to_month_day
  import date_pkg::*;
#(
  parameter int         DAY_W = 9,
  parameter logic [7:0] BLANK = BLANK_CODE
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [DAY_W-1:0] day_of_year,
  input  logic             leap,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [3:0]       month_bin,
  output logic [4:0]       day_bin,
  output logic [7:0]       month_tens,
  output logic [7:0]       month_ones,
  output logic [7:0]       day_tens,
  output logic [7:0]       day_ones,
  output state_t           dbg_state
);

  // Handshake: start is sampled only in IDLE; busy is high while the walk runs
  // (SUB/BCD of a valid request); done pulses for one cycle when the outputs
  // have been updated; requests arriving while busy or during done are dropped.

  localparam logic [DAY_W-1:0] MAX_NORM = DAY_W'(DAYS_NORMAL);
  localparam logic [DAY_W-1:0] MAX_LEAP = DAY_W'(DAYS_LEAP);
  localparam logic [DAY_W-1:0] TEN      = DAY_W'(10);

  state_t           state_q, state_d;
  logic [DAY_W-1:0] rem_q, rem_d;
  logic [3:0]       m_q, m_d;
  logic [1:0]       tens_q, tens_d;
  logic             leap_q, leap_d;
  logic             inv_q, inv_d;
  logic             err_q, err_d;
  logic [3:0]       month_bin_q, month_bin_d;
  logic [4:0]       day_bin_q, day_bin_d;
  logic [7:0]       month_tens_q, month_tens_d;
  logic [7:0]       month_ones_q, month_ones_d;
  logic [7:0]       day_tens_q, day_tens_d;
  logic [7:0]       day_ones_q, day_ones_d;

  logic [4:0]       len;
  logic             in_valid;

  month_len_rom u_len (
    .month_i (m_q),
    .leap_i  (leap_q),
    .days_o  (len)
  );

  assign in_valid = (day_of_year != '0) &&
                    (day_of_year <= (leap ? MAX_LEAP : MAX_NORM));

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      rem_q        <= '0;
      m_q          <= 4'd0;
      tens_q       <= 2'd0;
      leap_q       <= 1'b0;
      inv_q        <= 1'b0;
      err_q        <= 1'b0;
      month_bin_q  <= 4'd0;
      day_bin_q    <= 5'd0;
      month_tens_q <= BLANK;
      month_ones_q <= BLANK;
      day_tens_q   <= BLANK;
      day_ones_q   <= BLANK;
    end else begin
      state_q      <= state_d;
      rem_q        <= rem_d;
      m_q          <= m_d;
      tens_q       <= tens_d;
      leap_q       <= leap_d;
      inv_q        <= inv_d;
      err_q        <= err_d;
      month_bin_q  <= month_bin_d;
      day_bin_q    <= day_bin_d;
      month_tens_q <= month_tens_d;
      month_ones_q <= month_ones_d;
      day_tens_q   <= day_tens_d;
      day_ones_q   <= day_ones_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    rem_d        = rem_q;
    m_d          = m_q;
    tens_d       = tens_q;
    leap_d       = leap_q;
    inv_d        = inv_q;
    err_d        = err_q;
    month_bin_d  = month_bin_q;
    day_bin_d    = day_bin_q;
    month_tens_d = month_tens_q;
    month_ones_d = month_ones_q;
    day_tens_d   = day_tens_q;
    day_ones_d   = day_ones_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          rem_d   = day_of_year;
          leap_d  = leap;
          m_d     = 4'd1;
          tens_d  = 2'd0;
          inv_d   = !in_valid;
          // Invalid requests take one idle hop through BCD so done lands one edge later.
          state_d = in_valid ? ST_SUB : ST_BCD;
        end
      end
      ST_SUB: begin
        if (rem_q > DAY_W'(len)) begin
          rem_d = rem_q - DAY_W'(len);
          m_d   = m_q + 4'd1;
        end else begin
          tens_d  = 2'd0;
          state_d = ST_BCD;
        end
      end
      ST_BCD: begin
        if (inv_q) begin
          state_d      = ST_DONE;
          err_d        = 1'b1;
          month_bin_d  = 4'd0;
          day_bin_d    = 5'd0;
          month_tens_d = BLANK;
          month_ones_d = BLANK;
          day_tens_d   = BLANK;
          day_ones_d   = BLANK;
        end else if (rem_q >= TEN) begin
          rem_d  = rem_q - TEN;
          tens_d = tens_q + 2'd1;
        end else begin
          state_d      = ST_DONE;
          err_d        = 1'b0;
          month_bin_d  = m_q;
          day_bin_d    = 5'(tens_q) * 5'd10 + 5'(rem_q[3:0]);
          month_tens_d = (m_q >= 4'd10) ? 8'd1 : BLANK;
          month_ones_d = {4'd0, (m_q >= 4'd10) ? (m_q - 4'd10) : m_q};
          day_tens_d   = (tens_q == 2'd0) ? BLANK : {6'd0, tens_q};
          day_ones_d   = {4'd0, rem_q[3:0]};
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    busy      = ((state_q == ST_SUB) || (state_q == ST_BCD)) && !inv_q;
    done      = (state_q == ST_DONE);
    dbg_state = state_q;
  end

  assign err        = err_q;
  assign month_bin  = month_bin_q;
  assign day_bin    = day_bin_q;
  assign month_tens = month_tens_q;
  assign month_ones = month_ones_q;
  assign day_tens   = day_tens_q;
  assign day_ones   = day_ones_q;

endmodule

// File: tb/tb_doy_to_month_day.sv
// Directed bench for doy_to_month_day: hand-computed month/day/latency vectors.
module tb_doy_to_month_day;
  import date_pkg::*;

  localparam int DAY_W = 9;
  localparam int W     = 42;

  logic             clk = 1'b0;
  logic             reset;
  logic             start;
  logic [DAY_W-1:0] day_of_year;
  logic             leap;
  logic             busy, done, err;
  logic [3:0]       month_bin;
  logic [4:0]       day_bin;
  logic [7:0]       month_tens, month_ones, day_tens, day_ones;
  state_t           dbg_state;

  int n_checks = 0;
  int n_pass   = 0;
  logic [W-1:0] exp_q[$];

  // clock / reset block
  always #5 clk = ~clk;

  doy_to_month_day #(.DAY_W(DAY_W), .BLANK(8'd88)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .day_of_year (day_of_year),
    .leap        (leap),
    .busy        (busy),
    .done        (done),
    .err         (err),
    .month_bin   (month_bin),
    .day_bin     (day_bin),
    .month_tens  (month_tens),
    .month_ones  (month_ones),
    .day_tens    (day_tens),
    .day_ones    (day_ones),
    .dbg_state   (dbg_state)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Expected result record: {err, month_bin, day_bin, mt, mo, dt, do}
  function automatic logic [W-1:0] pack_exp(input logic e, input int m, input int d);
    logic [7:0] mt, mo, dt, dn;
    if (e) begin
      return {1'b1, 4'd0, 5'd0, 8'd88, 8'd88, 8'd88, 8'd88};
    end
    mt = (m >= 10) ? 8'd1 : 8'd88;
    mo = 8'(m % 10);
    dt = (d >= 10) ? 8'(d / 10) : 8'd88;
    dn = 8'(d % 10);
    return {1'b0, 4'(m), 5'(d), mt, mo, dt, dn};
  endfunction

  // Driver: one conversion, optionally poking a second start at edge poke_at.
  task automatic run_conv(input int day, input logic lp, input logic e,
                          input int m, input int d, input int lat_exp,
                          input int poke_at, input int poke_day);
    int lat;
    logic [W-1:0] ex;
    @(posedge clk); #1;
    check("done_one_cycle", done, 1'b0);
    start       = 1'b1;
    day_of_year = DAY_W'(day);
    leap        = lp;
    exp_q.push_back(pack_exp(e, m, d));
    @(posedge clk); #1;
    start       = 1'b0;
    day_of_year = DAY_W'(day + 7);
    leap        = ~lp;
    check("busy_after_start", busy, !e);
    lat = 0;
    while (!done && lat < 40) begin
      if (poke_at != 0 && lat + 1 == poke_at) begin
        start       = 1'b1;
        day_of_year = DAY_W'(poke_day);
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
      lat++;
    end
    start = 1'b0;
    check("done_seen", done, 1'b1);
    check("latency", lat, lat_exp);
    check("busy_at_done", busy, 1'b0);
    ex = exp_q.pop_front();
    check("err", err, ex[41]);
    check("month_bin", month_bin, ex[40:37]);
    check("day_bin", day_bin, ex[36:32]);
    check("digits", {month_tens, month_ones, day_tens, day_ones}, ex[31:0]);
  endtask

  initial begin
    reset       = 1'b1;
    start       = 1'b0;
    leap        = 1'b0;
    day_of_year = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_err", err, 1'b0);
    check("rst_bins", {month_bin, day_bin}, 9'd0);
    check("rst_digits", {month_tens, month_ones, day_tens, day_ones}, {4{8'd88}});
    reset = 1'b0;

    //       day  lp  e  m   d  lat poke
    run_conv(  1, 0, 0,  1,  1,  2, 0, 0);
    run_conv( 60, 0, 0,  3,  1,  4, 0, 0);
    run_conv( 60, 1, 0,  2, 29,  5, 0, 0);
    run_conv(365, 0, 0, 12, 31, 16, 0, 0);
    run_conv(366, 0, 1,  0,  0,  1, 0, 0);
    run_conv(  0, 1, 1,  0,  0,  1, 0, 0);
    run_conv(366, 1, 0, 12, 31, 16, 0, 0);
    run_conv( 10, 0, 0,  1, 10,  3, 0, 0);
    run_conv( 31, 0, 0,  1, 31,  5, 0, 0);
    run_conv(200, 0, 0,  7, 19,  9, 3, 5);
    run_conv(  5, 0, 0,  1,  5,  2, 0, 0);

    // Reset in the middle of a day-300 conversion.
    @(posedge clk); #1;
    start       = 1'b1;
    day_of_year = DAY_W'(300);
    leap        = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("busy_mid", busy, 1'b1);
    reset = 1'b1;
    @(posedge clk); #1;
    check("mid_rst_busy", busy, 1'b0);
    check("mid_rst_done", done, 1'b0);
    check("mid_rst_err", err, 1'b0);
    check("mid_rst_bins", {month_bin, day_bin}, 9'd0);
    check("mid_rst_digits", {month_tens, month_ones, day_tens, day_ones}, {4{8'd88}});
    reset = 1'b0;
    run_conv( 32, 0, 0,  2,  1,  3, 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
